// File: rtl/mt_pkg.sv
// mt_pkg: shared constants and state type for the Mersenne-Twister bus manager.
package mt_pkg;
  localparam logic [31:0] MT_RV_ADDR   = 32'h0;
  localparam logic [31:0] MT_SEED_ADDR = 32'h4;
  localparam int          MT_WORD_W    = 32;
  typedef enum logic [1:0] {IDLE, SEED, READ, OUT} mgr_state_t;
endpackage

// File: rtl/mt_bus_manager.sv
// mt_bus_manager: bus initiator that seeds the MT peripheral and streams random words out on valid/ready.
module mt_bus_manager
  import mt_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                seed_req,
  input  logic [DATA_W-1:0]   seed,
  output logic                seed_ack,
  input  logic                gen_start,
  input  logic [COUNT_W-1:0]  gen_count,
  output logic                busy,
  output logic                rv_valid,
  input  logic                rv_ready,
  output logic [DATA_W-1:0]   rv_data,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_wen,
  output logic                bus_ren,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_strobe,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_error,
  input  logic                bus_request_stall
);
  mgr_state_t         state_q, state_d;
  logic [DATA_W-1:0]  seed_q, seed_d, rv_data_q, rv_data_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  logic               rv_valid_q, rv_valid_d, done_q, done_d, seed_ack_q, seed_ack_d, err_q, err_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      seed_q     <= '0;
      rv_data_q  <= '0;
      rem_q      <= '0;
      rv_valid_q <= 1'b0;
      done_q     <= 1'b0;
      seed_ack_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      rv_data_q  <= rv_data_d;
      rem_q      <= rem_d;
      rv_valid_q <= rv_valid_d;
      done_q     <= done_d;
      seed_ack_q <= seed_ack_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    rv_data_d  = rv_data_q;
    rem_d      = rem_q;
    rv_valid_d = rv_valid_q;
    done_d     = 1'b0;
    seed_ack_d = 1'b0;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (seed_req) begin
          seed_d  = seed;
          err_d   = 1'b0;
          state_d = SEED;
        end else if (gen_start) begin
          err_d   = 1'b0;
          rem_d   = gen_count;
          done_d  = (gen_count == '0);
          state_d = (gen_count == '0) ? IDLE : READ;
        end
      end
      SEED: begin
        if (!bus_request_stall) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          seed_ack_d = !bus_error;
          err_d      = err_q | bus_error;
        end
      end
      READ: begin
        if (!bus_request_stall) begin
          if (bus_error) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rv_data_d  = bus_rdata;
            rv_valid_d = 1'b1;
            state_d    = OUT;
          end
        end
      end
      OUT: begin
        if (rv_ready) begin
          rv_valid_d = 1'b0;
          rem_d      = rem_q - 1'b1;
          done_d     = (rem_q == COUNT_W'(1));
          state_d    = (rem_q == COUNT_W'(1)) ? IDLE : READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus side is a pure decode of registered state so no input reaches it combinationally.
  assign bus_wen    = (state_q == SEED);
  assign bus_ren    = (state_q == READ);
  assign bus_addr   = bus_wen ? ADDR_W'(MT_SEED_ADDR) : ADDR_W'(MT_RV_ADDR);
  assign bus_wdata  = bus_wen ? seed_q : '0;
  assign bus_strobe = (bus_wen || bus_ren) ? '1 : '0;
  assign busy       = (state_q != IDLE);
  assign rv_valid   = rv_valid_q;
  assign rv_data    = rv_data_q;
  assign done       = done_q;
  assign seed_ack   = seed_ack_q;
  assign err        = err_q;
endmodule
